// File: rtl/key_debounce_sync.sv
// Conditions one raw push-button pin for a PIO input: 2-FF synchroniser,
// polarity normalisation, counter debounce and single-cycle edge pulses.
module key_debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic key_level,
   output logic key_rise,
   output logic key_fall,
   output logic busy
);

   localparam logic             IDLE_PIN = ACTIVE_LOW;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, PENDING} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sync1, sync2, sample;
   logic             level_nxt, rise_nxt, fall_nxt, accept;

   // Synchroniser resets to the released pin level so reset never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= IDLE_PIN;
         sync2 <= IDLE_PIN;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign sample = ACTIVE_LOW ? ~sync2 : sync2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = key_level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      accept    = 1'b0;
      case (state)
         STABLE: begin
            if (sample != key_level) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  accept = 1'b1;
               end else begin
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = PENDING;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         PENDING: begin
            // A bounce back to the current level forfeits all accumulated credit.
            if (sample == key_level) begin
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else if (cnt >= CNT_MAX) begin
               accept = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = STABLE;
         end
      endcase
      if (accept) begin
         level_nxt = sample;
         cnt_nxt   = '0;
         state_nxt = STABLE;
         rise_nxt  = sample;
         fall_nxt  = ~sample;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= STABLE;
         cnt       <= '0;
         key_level <= 1'b0;
         key_rise  <= 1'b0;
         key_fall  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         key_level <= level_nxt;
         key_rise  <= rise_nxt;
         key_fall  <= fall_nxt;
         busy      <= (state_nxt == PENDING);
      end
   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync: default-polarity instance (4-cycle
// debounce) plus an active-high, single-cycle instance.
module tb_key_debounce_sync;

   logic clk = 1'b0;
   logic reset_n;
   logic key_raw, key_raw_p;
   logic key_level, key_rise, key_fall, busy;
   logic key_level_p, key_rise_p, key_fall_p, busy_p;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   key_debounce_sync #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
      .key_level(key_level), .key_rise(key_rise), .key_fall(key_fall), .busy(busy)
   );

   key_debounce_sync #(.DEBOUNCE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b0)) dut_p (
      .clk(clk), .reset_n(reset_n), .key_raw(key_raw_p),
      .key_level(key_level_p), .key_rise(key_rise_p), .key_fall(key_fall_p), .busy(busy_p)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {key_level, key_rise, key_fall, busy}
   function automatic logic [3:0] outs();
      return {key_level, key_rise, key_fall, busy};
   endfunction

   function automatic logic [3:0] outs_p();
      return {key_level_p, key_rise_p, key_fall_p, busy_p};
   endfunction

   // Expected vectors for edges 1..8 after a held pin change.
   logic [3:0] press_exp   [1:8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000, 4'b1000};
   logic [3:0] release_exp [1:8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000, 4'b0000};
   logic       bounce_seq  [0:8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [3:0] bounce_exp  [1:14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                      4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000, 4'b1000, 4'b1000};

   initial begin
      int rises;
      reset_n   = 1'b0;
      key_raw   = 1'b1;
      key_raw_p = 1'b0;

      // 1. reset, then idle for 20 cycles
      repeat (3) tick();
      chk("reset_outs", 32'(outs()), 32'h0);
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("idle_outs", 32'(outs()), 32'h0);
      end
      chk("idle_outs_p", 32'(outs_p()), 32'h0);

      // 2. press held
      key_raw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("press_e%0d", k), 32'(outs()), 32'(press_exp[k]));
      end

      // 3. release held
      key_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("release_e%0d", k), 32'(outs()), 32'(release_exp[k]));
      end

      // 4. bounce: 3-sample glitch rejected, 4-sample run accepted
      rises = 0;
      key_raw = bounce_seq[0];
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk($sformatf("bounce_e%0d", k), 32'(outs()), 32'(bounce_exp[k]));
         if (key_rise) rises++;
         key_raw = (k < 9) ? bounce_seq[k] : 1'b0;
      end
      chk("bounce_rises", 32'(rises), 32'd1);

      // 5. reset mid-PENDING: release first, then start a press and reset at cnt=2
      key_raw = 1'b1;
      repeat (8) tick();
      chk("pre5_released", 32'(outs()), 32'h0);
      key_raw = 1'b0;
      repeat (4) tick();
      chk("pre5_busy", 32'(outs()), 32'b0001);
      reset_n = 1'b0;
      #1;
      chk("async_reset_outs", 32'(outs()), 32'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      rises = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("post_rst_e%0d", k), 32'(outs()), 32'(press_exp[k]));
         if (key_rise) rises++;
      end
      chk("post_rst_rises", 32'(rises), 32'd1);

      // 6. DEBOUNCE_CYCLES=1, active-high instance
      chk("p_idle", 32'(outs_p()), 32'h0);
      key_raw_p = 1'b1;
      tick(); chk("p_press_e1", 32'(outs_p()), 32'b0000);
      tick(); chk("p_press_e2", 32'(outs_p()), 32'b0000);
      tick(); chk("p_press_e3", 32'(outs_p()), 32'b1100);
      tick(); chk("p_press_e4", 32'(outs_p()), 32'b1000);
      key_raw_p = 1'b0;
      tick(); chk("p_release_e1", 32'(outs_p()), 32'b1000);
      tick(); chk("p_release_e2", 32'(outs_p()), 32'b1000);
      tick(); chk("p_release_e3", 32'(outs_p()), 32'b0010);
      tick(); chk("p_release_e4", 32'(outs_p()), 32'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
